decode_stage: RTL and testbench

- Instruction-decode pipeline stage of the LEGv8 CPU, between the IF/ID latch and the EX stage.
- Extracts register indices from the fetched instruction and drives the register bank read addresses.
- Captures the bank read data, with write-back bypass, together with the decoded immediate and control flags into the ID/EX pipeline register.
- Detects load-use hazards against the instruction it issued last cycle. On a hazard it stalls fetch and inserts a bubble.

---
 rtl/decode_stage.sv | 155 +++++++++++++++
 tb/tb_decode_stage.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// LEGv8 instruction-decode stage: register-index extraction, write-back bypass,
// immediate/control decode, load-use hazard detection and the ID/EX register.
module decode_stage #(
  parameter int unsigned DATA_WIDTH    = 64,
  parameter int unsigned ADDRESS_WIDTH = 64
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     if_valid,
  input  logic [31:0]              if_instruction,
  input  logic [DATA_WIDTH-1:0]    if_pc,
  input  logic                     flush,
  input  logic                     wb_write,
  input  logic [4:0]               wb_address,
  input  logic [DATA_WIDTH-1:0]    wb_data,
  output logic [ADDRESS_WIDTH-1:0] rb_address_1,
  output logic [ADDRESS_WIDTH-1:0] rb_address_2,
  input  logic [DATA_WIDTH-1:0]    rb_data_1,
  input  logic [DATA_WIDTH-1:0]    rb_data_2,
  output logic                     stall,
  output logic                     id_valid,
  output logic [DATA_WIDTH-1:0]    id_pc,
  output logic [DATA_WIDTH-1:0]    id_data_1,
  output logic [DATA_WIDTH-1:0]    id_data_2,
  output logic [DATA_WIDTH-1:0]    id_immediate,
  output logic [4:0]               id_rd,
  output logic [10:0]              id_opcode,
  output logic                     id_reg_write,
  output logic                     id_mem_read,
  output logic                     id_mem_write,
  output logic                     id_branch
);

  logic [4:0] rn;
  logic [4:0] reg2;
  logic [DATA_WIDTH-1:0] operand_1;
  logic [DATA_WIDTH-1:0] operand_2;
  logic [DATA_WIDTH-1:0] immediate;
  logic reg_write;
  logic mem_read;
  logic mem_write;
  logic branch;
  logic hazard;

  logic                  id_valid_q;
  logic [DATA_WIDTH-1:0] id_pc_q;
  logic [DATA_WIDTH-1:0] id_data_1_q;
  logic [DATA_WIDTH-1:0] id_data_2_q;
  logic [DATA_WIDTH-1:0] id_immediate_q;
  logic [4:0]            id_rd_q;
  logic [10:0]           id_opcode_q;
  logic                  id_reg_write_q;
  logic                  id_mem_read_q;
  logic                  id_mem_write_q;
  logic                  id_branch_q;

  // STUR/CBZ/CBNZ (and every other bit-28 format) read their second register from Rt.
  assign rn   = if_instruction[9:5];
  assign reg2 = if_instruction[28] ? if_instruction[4:0] : if_instruction[20:16];

  assign rb_address_1 = ADDRESS_WIDTH'(rn);
  assign rb_address_2 = ADDRESS_WIDTH'(reg2);

  // Write-back bypass: the bank write lands this same edge, so forward it.
  always_comb begin
    operand_1 = rb_data_1;
    operand_2 = rb_data_2;
    if (wb_write && (wb_address == rn))   operand_1 = wb_data;
    if (wb_write && (wb_address == reg2)) operand_2 = wb_data;
  end

  // Instruction-class decode: immediate extension and control flags.
  always_comb begin
    immediate = '0;
    reg_write = 1'b1;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    branch    = 1'b0;
    if ((if_instruction[31:26] == 6'b000101) || (if_instruction[31:26] == 6'b100101)) begin
      immediate = {{(DATA_WIDTH-26){if_instruction[25]}}, if_instruction[25:0]};
      reg_write = 1'b0;
      branch    = 1'b1;
    end else if ((if_instruction[31:24] == 8'b10110100) ||
                 (if_instruction[31:24] == 8'b10110101)) begin
      immediate = {{(DATA_WIDTH-19){if_instruction[23]}}, if_instruction[23:5]};
      reg_write = 1'b0;
      branch    = 1'b1;
    end else if (if_instruction[31:21] == 11'b11111000010) begin
      immediate = {{(DATA_WIDTH-9){if_instruction[20]}}, if_instruction[20:12]};
      mem_read  = 1'b1;
    end else if (if_instruction[31:21] == 11'b11111000000) begin
      immediate = {{(DATA_WIDTH-9){if_instruction[20]}}, if_instruction[20:12]};
      reg_write = 1'b0;
      mem_write = 1'b1;
    end else if ((if_instruction[31:22] == 10'b1001000100) ||
                 (if_instruction[31:22] == 10'b1101000100)) begin
      immediate = {{(DATA_WIDTH-12){1'b0}}, if_instruction[21:10]};
    end
  end

  // Load-use hazard against the instruction now in ID/EX; X31 as load target never stalls.
  always_comb begin
    hazard = id_valid_q & id_mem_read_q & (id_rd_q != 5'd31) & if_valid &
             ((id_rd_q == rn) | (id_rd_q == reg2));
    stall  = hazard & ~flush;
  end

  // ID/EX pipeline register: bubbles keep data fields, clearing only valid and flags.
  always_ff @(posedge clock) begin
    if (reset) begin
      id_valid_q     <= 1'b0;
      id_pc_q        <= '0;
      id_data_1_q    <= '0;
      id_data_2_q    <= '0;
      id_immediate_q <= '0;
      id_rd_q        <= '0;
      id_opcode_q    <= '0;
      id_reg_write_q <= 1'b0;
      id_mem_read_q  <= 1'b0;
      id_mem_write_q <= 1'b0;
      id_branch_q    <= 1'b0;
    end else if (flush || hazard) begin
      id_valid_q     <= 1'b0;
      id_reg_write_q <= 1'b0;
      id_mem_read_q  <= 1'b0;
      id_mem_write_q <= 1'b0;
      id_branch_q    <= 1'b0;
    end else begin
      id_valid_q     <= if_valid;
      id_pc_q        <= if_pc;
      id_data_1_q    <= operand_1;
      id_data_2_q    <= operand_2;
      id_immediate_q <= immediate;
      id_rd_q        <= if_instruction[4:0];
      id_opcode_q    <= if_instruction[31:21];
      id_reg_write_q <= reg_write & if_valid;
      id_mem_read_q  <= mem_read & if_valid;
      id_mem_write_q <= mem_write & if_valid;
      id_branch_q    <= branch & if_valid;
    end
  end

  assign id_valid     = id_valid_q;
  assign id_pc        = id_pc_q;
  assign id_data_1    = id_data_1_q;
  assign id_data_2    = id_data_2_q;
  assign id_immediate = id_immediate_q;
  assign id_rd        = id_rd_q;
  assign id_opcode    = id_opcode_q;
  assign id_reg_write = id_reg_write_q;
  assign id_mem_read  = id_mem_read_q;
  assign id_mem_write = id_mem_write_q;
  assign id_branch    = id_branch_q;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: directed LEGv8 vectors, monitor pops on id_valid.
module tb_decode_stage;

  logic        clock = 1'b0;
  logic        reset;
  logic        if_valid;
  logic [31:0] if_instruction;
  logic [63:0] if_pc;
  logic        flush;
  logic        wb_write;
  logic [4:0]  wb_address;
  logic [63:0] wb_data;
  logic [63:0] rb_address_1, rb_address_2;
  logic [63:0] rb_data_1, rb_data_2;
  logic        stall, id_valid;
  logic [63:0] id_pc, id_data_1, id_data_2, id_immediate;
  logic [4:0]  id_rd;
  logic [10:0] id_opcode;
  logic        id_reg_write, id_mem_read, id_mem_write, id_branch;

  typedef struct packed {
    logic [63:0] pc;
    logic [63:0] d1;
    logic [63:0] d2;
    logic [63:0] imm;
    logic [4:0]  rd;
    logic [10:0] opc;
    logic        rw;
    logic        mr;
    logic        mw;
    logic        br;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_exp;
  exp_t        mon_act;
  logic [63:0] bank [32];
  int          checks   = 0;
  int          failures = 0;

  always #5 clock = ~clock;

  assign rb_data_1 = bank[rb_address_1[4:0]];
  assign rb_data_2 = bank[rb_address_2[4:0]];

  decode_stage #(.DATA_WIDTH(64), .ADDRESS_WIDTH(64)) dut (
    .clock          (clock),
    .reset          (reset),
    .if_valid       (if_valid),
    .if_instruction (if_instruction),
    .if_pc          (if_pc),
    .flush          (flush),
    .wb_write       (wb_write),
    .wb_address     (wb_address),
    .wb_data        (wb_data),
    .rb_address_1   (rb_address_1),
    .rb_address_2   (rb_address_2),
    .rb_data_1      (rb_data_1),
    .rb_data_2      (rb_data_2),
    .stall          (stall),
    .id_valid       (id_valid),
    .id_pc          (id_pc),
    .id_data_1      (id_data_1),
    .id_data_2      (id_data_2),
    .id_immediate   (id_immediate),
    .id_rd          (id_rd),
    .id_opcode      (id_opcode),
    .id_reg_write   (id_reg_write),
    .id_mem_read    (id_mem_read),
    .id_mem_write   (id_mem_write),
    .id_branch      (id_branch)
  );

  function automatic logic [31:0] enc_r(input logic [4:0] rd, rn, rm);
    return {11'b10001011000, rm, 6'b0, rn, rd};
  endfunction

  function automatic logic [31:0] enc_ldur(input logic [4:0] rt, rn, input logic [8:0] imm);
    return {11'b11111000010, imm, 2'b00, rn, rt};
  endfunction

  function automatic logic [31:0] enc_stur(input logic [4:0] rt, rn, input logic [8:0] imm);
    return {11'b11111000000, imm, 2'b00, rn, rt};
  endfunction

  task automatic chk(input string name, input logic [319:0] act, input logic [319:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [63:0] pc, d1, d2, imm, input logic [4:0] rd,
                      input logic [10:0] opc, input logic rw, mr, mw, br);
    exp_t e;
    e = '{pc: pc, d1: d1, d2: d2, imm: imm, rd: rd, opc: opc, rw: rw, mr: mr, mw: mw, br: br};
    sb.push_back(e);
  endtask

  // Drive one cycle of inputs at the falling edge, check stall, then step past the rising edge.
  task automatic apply(input logic rst, v, input logic [31:0] ins, input logic [63:0] pc,
                       input logic fl, wbw, input logic [4:0] wba, input logic [63:0] wbd,
                       input logic exp_stall, input string name);
    @(negedge clock);
    reset          = rst;
    if_valid       = v;
    if_instruction = ins;
    if_pc          = pc;
    flush          = fl;
    wb_write       = wbw;
    wb_address     = wba;
    wb_data        = wbd;
    #1;
    chk({name, " stall"}, {319'b0, stall}, {319'b0, exp_stall});
    @(posedge clock);
    #2;
  endtask

  task automatic chk_all_zero(input string name);
    chk(name, {id_valid, id_pc, id_data_1, id_data_2, id_immediate, id_rd, id_opcode,
               id_reg_write, id_mem_read, id_mem_write, id_branch}, '0);
  endtask

  // Monitor: every valid ID/EX presentation must match the oldest expectation.
  always @(posedge clock) begin
    #1;
    if (id_valid === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL issue: got unexpected valid pc=%0h expected no issue", id_pc);
      end else begin
        mon_exp = sb.pop_front();
        mon_act = '{pc: id_pc, d1: id_data_1, d2: id_data_2, imm: id_immediate, rd: id_rd,
                    opc: id_opcode, rw: id_reg_write, mr: id_mem_read, mw: id_mem_write,
                    br: id_branch};
        if (mon_act !== mon_exp) begin
          failures++;
          $display("FAIL issue pc=%0h: got %0h expected %0h", mon_exp.pc, mon_act, mon_exp);
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < 32; i++) bank[i] = 64'h1000 + 64'(i);
    bank[1] = 64'd5;
    bank[2] = 64'd7;

    // Reset with a load-dependent instruction presented: nothing issues, no stall.
    apply(1'b1, 1'b1, enc_r(5'd3, 5'd1, 5'd2), 64'h0, 1'b0, 1'b0, 5'd0, 64'h0, 1'b0, "rst0");
    apply(1'b1, 1'b1, enc_r(5'd3, 5'd1, 5'd2), 64'h0, 1'b0, 1'b0, 5'd0, 64'h0, 1'b0, "rst1");
    chk_all_zero("reset outputs");

    // ADD X3,X1,X2
    push(64'h100, 64'd5, 64'd7, 64'h0, 5'd3, 11'b10001011000, 1'b1, 1'b0, 1'b0, 1'b0);
    apply(1'b0, 1'b1, enc_r(5'd3, 5'd1, 5'd2), 64'h100, 1'b0, 1'b0, 5'd0, 64'h0, 1'b0, "add");

    // LDUR X4,[X1,#-8]; bit 28 set so the second read port follows Rt = X4
    push(64'h104, 64'd5, 64'h1004, 64'hFFFF_FFFF_FFFF_FFF8, 5'd4, 11'b11111000010,
         1'b1, 1'b1, 1'b0, 1'b0);
    apply(1'b0, 1'b1, enc_ldur(5'd4, 5'd1, 9'h1F8), 64'h104, 1'b0, 1'b0, 5'd0, 64'h0, 1'b0,
          "ldur");

    // ADD X5,X4,X2 depends on the load: one stall cycle and a bubble
    apply(1'b0, 1'b1, enc_r(5'd5, 5'd4, 5'd2), 64'h108, 1'b0, 1'b0, 5'd0, 64'h0, 1'b1,
          "hazard");
    chk("bubble valid", {319'b0, id_valid}, 320'd0);
    chk("bubble flags", {316'b0, id_reg_write, id_mem_read, id_mem_write, id_branch}, 320'd0);
    chk("bubble rd hold", {315'b0, id_rd}, {315'b0, 5'd4});

    push(64'h108, 64'h1004, 64'd7, 64'h0, 5'd5, 11'b10001011000, 1'b1, 1'b0, 1'b0, 1'b0);
    apply(1'b0, 1'b1, enc_r(5'd5, 5'd4, 5'd2), 64'h108, 1'b0, 1'b0, 5'd0, 64'h0, 1'b0,
          "add after stall");

    // LDUR X31 then a consumer of X31: no stall
    push(64'h10C, 64'd5, 64'h101F, 64'h0, 5'd31, 11'b11111000010, 1'b1, 1'b1, 1'b0, 1'b0);
    apply(1'b0, 1'b1, enc_ldur(5'd31, 5'd1, 9'h0), 64'h10C, 1'b0, 1'b0, 5'd0, 64'h0, 1'b0,
          "ldur x31");
    push(64'h110, 64'h101F, 64'd7, 64'h0, 5'd5, 11'b10001011000, 1'b1, 1'b0, 1'b0, 1'b0);
    apply(1'b0, 1'b1, enc_r(5'd5, 5'd31, 5'd2), 64'h110, 1'b0, 1'b0, 5'd0, 64'h0, 1'b0,
          "x31 no stall");

    // Write-back bypass onto operand 2
    push(64'h114, 64'd5, 64'hAA, 64'h0, 5'd3, 11'b10001011000, 1'b1, 1'b0, 1'b0, 1'b0);
    apply(1'b0, 1'b1, enc_r(5'd3, 5'd1, 5'd2), 64'h114, 1'b0, 1'b1, 5'd2, 64'hAA, 1'b0,
          "bypass");

    // CBZ X9,#-1: Rn field = 31, reg2 = Rt = 9
    push(64'h118, 64'h101F, 64'h1009, 64'hFFFF_FFFF_FFFF_FFFF, 5'd9, 11'b10110100111,
         1'b0, 1'b0, 1'b0, 1'b1);
    apply(1'b0, 1'b1, {8'hB4, 19'h7FFFF, 5'd9}, 64'h118, 1'b0, 1'b0, 5'd0, 64'h0, 1'b0, "cbz");
    chk("cbz rb_address_2", {256'b0, rb_address_2}, 320'd9);

    // ADDI X6,X1,#0xFFF zero-extends
    push(64'h11C, 64'd5, 64'h1006, 64'hFFF, 5'd6, 11'b10010001001, 1'b1, 1'b0, 1'b0, 1'b0);
    apply(1'b0, 1'b1, {10'b1001000100, 12'hFFF, 5'd1, 5'd6}, 64'h11C, 1'b0, 1'b0, 5'd0,
          64'h0, 1'b0, "addi");

    // STUR X7,[X2,#16]
    push(64'h120, 64'd7, 64'h1007, 64'd16, 5'd7, 11'b11111000000, 1'b0, 1'b0, 1'b1, 1'b0);
    apply(1'b0, 1'b1, enc_stur(5'd7, 5'd2, 9'd16), 64'h120, 1'b0, 1'b0, 5'd0, 64'h0, 1'b0,
          "stur");

    // B #-2
    push(64'h124, 64'h101F, 64'h101E, 64'hFFFF_FFFF_FFFF_FFFE, 5'd30, 11'b00010111111,
         1'b0, 1'b0, 1'b0, 1'b1);
    apply(1'b0, 1'b1, {6'b000101, 26'h3FFFFFE}, 64'h124, 1'b0, 1'b0, 5'd0, 64'h0, 1'b0, "b");

    // Invalid slot: nothing issues
    apply(1'b0, 1'b0, enc_r(5'd3, 5'd1, 5'd2), 64'h128, 1'b0, 1'b0, 5'd0, 64'h0, 1'b0,
          "idle");
    chk("idle flags", {315'b0, id_valid, id_reg_write, id_mem_read, id_mem_write, id_branch},
        320'd0);

    // Load, then flush alongside the hazard: bubble, no stall, data fields held
    push(64'h12C, 64'd5, 64'h1004, 64'hFFFF_FFFF_FFFF_FFF8, 5'd4, 11'b11111000010,
         1'b1, 1'b1, 1'b0, 1'b0);
    apply(1'b0, 1'b1, enc_ldur(5'd4, 5'd1, 9'h1F8), 64'h12C, 1'b0, 1'b0, 5'd0, 64'h0, 1'b0,
          "ldur 2");
    apply(1'b0, 1'b1, enc_r(5'd5, 5'd4, 5'd2), 64'h130, 1'b1, 1'b0, 5'd0, 64'h0, 1'b0,
          "flush hazard");
    chk("flush bubble valid", {319'b0, id_valid}, 320'd0);
    chk("flush hold", {id_pc, id_immediate, id_rd, id_mem_read},
        {64'h12C, 64'hFFFF_FFFF_FFFF_FFF8, 5'd4, 1'b0});

    // Reissue, then reset mid-stream
    push(64'h134, 64'd5, 64'd7, 64'h0, 5'd3, 11'b10001011000, 1'b1, 1'b0, 1'b0, 1'b0);
    apply(1'b0, 1'b1, enc_r(5'd3, 5'd1, 5'd2), 64'h134, 1'b0, 1'b0, 5'd0, 64'h0, 1'b0,
          "add 2");
    apply(1'b1, 1'b1, enc_r(5'd3, 5'd1, 5'd2), 64'h138, 1'b0, 1'b0, 5'd0, 64'h0, 1'b0,
          "mid reset");
    chk_all_zero("mid reset outputs");

    push(64'h13C, 64'd5, 64'd7, 64'h0, 5'd3, 11'b10001011000, 1'b1, 1'b0, 1'b0, 1'b0);
    apply(1'b0, 1'b1, enc_r(5'd3, 5'd1, 5'd2), 64'h13C, 1'b0, 1'b0, 5'd0, 64'h0, 1'b0,
          "after reset");
    apply(1'b0, 1'b0, 32'h0, 64'h0, 1'b0, 1'b0, 5'd0, 64'h0, 1'b0, "drain");

    chk("scoreboard drained", 320'(sb.size()), 320'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
